// File: rtl/ram8_copy_engine_pkg.sv
// Shared constants for the RAM8 copy engine: default sizes, opcodes and state encodings.
package ram8_copy_engine_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/ram8_copy_engine.sv
// FILL/COPY initiator for an external 8-word RAM with combinational read and
// same-edge write. One command at a time, no queueing.
module ram8_copy_engine
  import ram8_copy_engine_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  mem_in,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [WIDTH-1:0]  mem_out
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      i     <= '0;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      data  <= '0;
      hold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            src   <= cmd_src;
            dst   <= cmd_dst;
            len   <= cmd_len;
            data  <= cmd_data;
            i     <= '0;
            state <= (cmd_op == OP_COPY) ? S_RD : S_FILL;
          end
        end
        S_FILL: begin
          i <= i + 1'b1;
          if (i == len) state <= S_DONE;
        end
        S_RD: begin
          hold  <= mem_out;
          state <= S_WR;
        end
        S_WR: begin
          if (i == len) begin
            state <= S_DONE;
          end else begin
            i     <= i + 1'b1;
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode from registered state only, so reset kills mem_load
  // asynchronously and nothing can glitch it high in IDLE, RD or DONE.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    case (state)
      S_FILL: begin
        mem_load    = 1'b1;
        mem_address = dst + i;
        mem_in      = data;
      end
      S_RD: mem_address = src + i;
      S_WR: begin
        mem_load    = 1'b1;
        mem_address = dst + i;
        mem_in      = hold;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_ram8_copy_engine.sv
// Self-checking bench for ram8_copy_engine with a behavioural RAM8 responder
// (combinational read, write on the same edge as mem_load).
module tb_ram8_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [2:0]  cmd_src;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_len;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [2:0]  mem_address;
  logic [15:0] mem_out;

  // Bench-side write port used only to preload the RAM while the engine is idle.
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_load)    ram[mem_address] <= mem_in;
    else if (pre_we) ram[pre_addr]    <= pre_data;
  end
  assign mem_out = ram[mem_address];

  ram8_copy_engine dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .done        (done),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .mem_out     (mem_out)
  );

  typedef struct {
    logic            op;
    logic [2:0]      src;
    logic [2:0]      dst;
    logic [2:0]      len;
    logic [15:0]     data;
    logic [7:0][15:0] init;
    logic [7:0][15:0] exp;
    int              cycles;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][15:0] ramp(input logic [15:0] base);
    logic [7:0][15:0] r;
    for (int k = 0; k < 8; k++) r[k] = base + 16'(k);
    return r;
  endfunction

  task automatic preload(input logic [7:0][15:0] init);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 3'(k);
      pre_data = init[k];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_ram(input string name, input logic [7:0][15:0] exp);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s word%0d", name, k), 64'(ram[k]), 64'(exp[k]));
  endtask

  // Presents a command at a negedge, checks it is accepted, drops valid.
  // Returns positioned at the negedge of the first busy cycle.
  task automatic issue(input logic op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [2:0] len, input logic [15:0] data);
    @(negedge clk);
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    check("accept ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [15:0]     load_mask, exp_mask;
    logic [7:0][2:0] addr_seq, exp_addr;
    logic [7:0][15:0] exp_ram;
    int              cyc, loads;
    bit              got_done, saw_done;
    logic [15:0]     rdy_mask, done_mask;
    bit              busy_bad;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;

    @(negedge clk);
    check("reset cmd_ready",   64'(cmd_ready),   64'd1);
    check("reset busy",        64'(busy),        64'd0);
    check("reset done",        64'(done),        64'd0);
    check("reset mem_load",    64'(mem_load),    64'd0);
    check("reset mem_address", 64'(mem_address), 64'd0);
    check("reset mem_in",      64'(mem_in),      64'd0);
    reset = 1'b0;

    // Expected RAM images are written word7..word0.
    vecs[0] = '{1'b0, 3'd5, 3'd2, 3'd3, 16'hBEEF, ramp(16'h0000),
                {16'h0007, 16'h0006, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0001, 16'h0000}, 5};
    vecs[1] = '{1'b1, 3'd0, 3'd4, 3'd3, 16'hDEAD, ramp(16'h1000),
                {16'h1003, 16'h1002, 16'h1001, 16'h1000, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 9};
    vecs[2] = '{1'b0, 3'd1, 3'd6, 3'd3, 16'h0A0A, ramp(16'h0000),
                {16'h0A0A, 16'h0A0A, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0A0A, 16'h0A0A}, 5};
    vecs[3] = '{1'b1, 3'd0, 3'd1, 3'd3, 16'h0000, ramp(16'h0000),
                {16'h0007, 16'h0006, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 9};
    vecs[4] = '{1'b1, 3'd5, 3'd5, 3'd0, 16'h7777, ramp(16'h1000),
                {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 3};
    vecs[5] = '{1'b0, 3'd3, 3'd0, 3'd7, 16'hFFFF, ramp(16'h2000),
                {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 9};

    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].init);
      issue(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].data);
      load_mask = '0;
      addr_seq  = '0;
      cyc       = 0;
      loads     = 0;
      got_done  = 1'b0;
      while (!got_done && cyc < 20) begin
        cyc++;
        load_mask[cyc-1] = mem_load;
        if (mem_load) begin
          if (loads < 8) addr_seq[loads] = mem_address;
          loads++;
        end
        if (done) got_done = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("v%0d done seen", v), 64'(got_done), 64'd1);
      check($sformatf("v%0d busy cycles", v), 64'(cyc), 64'(vecs[v].cycles));
      check($sformatf("v%0d load count", v), 64'(loads), 64'(vecs[v].len) + 64'd1);
      exp_mask = '0;
      exp_addr = '0;
      for (int k = 1; k <= vecs[v].cycles; k++) begin
        if (vecs[v].op == 1'b0) exp_mask[k-1] = (k <= int'(vecs[v].len) + 1);
        else                    exp_mask[k-1] = (k % 2 == 0) && (k < vecs[v].cycles);
      end
      for (int k = 0; k <= int'(vecs[v].len); k++) exp_addr[k] = vecs[v].dst + 3'(k);
      check($sformatf("v%0d load pattern", v), 64'(load_mask), 64'(exp_mask));
      check($sformatf("v%0d write addresses", v), 64'(addr_seq), 64'(exp_addr));
      @(negedge clk);
      check($sformatf("v%0d done one cycle", v), 64'(done), 64'd0);
      check($sformatf("v%0d ready after", v), 64'(cmd_ready), 64'd1);
      check_ram($sformatf("v%0d ram", v), vecs[v].exp);
    end

    // Reset lands in the write of word index 2, after words 0 and 1 are stored.
    preload(ramp(16'h1000));
    issue(1'b1, 3'd0, 3'd3, 3'd7, 16'h0000);
    repeat (5) @(negedge clk);
    check("rst-mid mem_load before", 64'(mem_load), 64'd1);
    check("rst-mid address before", 64'(mem_address), 64'd5);
    reset = 1'b1;
    #1;
    check("rst-mid mem_load drop", 64'(mem_load), 64'd0);
    check("rst-mid cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst-mid busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rst-mid no done", 64'(saw_done), 64'd0);
    exp_ram = ramp(16'h1000);
    exp_ram[3] = 16'h1000;
    exp_ram[4] = 16'h1001;
    check_ram("rst-mid ram", exp_ram);

    // cmd_valid held high: accept every 4th cycle, each right after a done.
    preload(ramp(16'h0000));
    @(negedge clk);
    cmd_op    = 1'b0;
    cmd_dst   = 3'd0;
    cmd_src   = 3'd0;
    cmd_len   = 3'd1;
    cmd_data  = 16'h1234;
    cmd_valid = 1'b1;
    rdy_mask  = '0;
    done_mask = '0;
    busy_bad  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rdy_mask[k]  = cmd_ready;
      done_mask[k] = done;
      if (busy === cmd_ready) busy_bad = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("b2b ready pattern", 64'(rdy_mask), 64'h1111);
    check("b2b done pattern", 64'(done_mask), 64'h8888);
    check("b2b busy is not ready", 64'(busy_bad), 64'd0);
    @(negedge clk);
    check("b2b idle at end", 64'(cmd_ready), 64'd1);
    check("b2b word0", 64'(ram[0]), 64'h1234);
    check("b2b word1", 64'(ram[1]), 64'h1234);
    check("b2b word2", 64'(ram[2]), 64'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
